// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two writeback requesters and the register-file write arbiter.
// The master modport is the requester side. The slave modport is the arbiter side.
interface regfile_wb_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;

    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_done;
    logic        grant_id;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  rf_we, rf_waddr, rf_wdata, init_done, grant_id
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output rf_we, rf_waddr, rf_wdata, init_done, grant_id
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: zero-sweeps x1..x31 after reset, then grants one of two requesters per cycle.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise requester 0 has fixed priority.
module regfile_wb_arbiter (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);
    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg, count_next;
    logic        rf_we_reg, rf_we_next;
    logic [4:0]  rf_waddr_reg, rf_waddr_next;
    logic [31:0] rf_wdata_reg, rf_wdata_next;
    logic        init_done_reg, init_done_next;
    logic        grant_id_reg, grant_id_next;

    logic [1:0]  valid_vec;
    logic [1:0]  ready_vec;
    logic [4:0]  addr_vec [2];
    logic [31:0] data_vec [2];
    logic        grant_sel;
    logic        transfer;

    assign valid_vec   = {bus.req1_valid, bus.req0_valid};
    assign addr_vec[0] = bus.req0_addr;
    assign addr_vec[1] = bus.req1_addr;
    assign data_vec[0] = bus.req0_data;
    assign data_vec[1] = bus.req1_data;

`ifdef WB_ARB_ROUND_ROBIN_EN
    // Pointer names the requester that wins the next contention.
    logic ptr_reg, ptr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (transfer) begin
            ptr_next = ~grant_sel;
        end
    end

    assign grant_sel = (&valid_vec) ? ptr_reg : valid_vec[1];
`else
    assign grant_sel = ~valid_vec[0] & valid_vec[1];
`endif

    assign transfer = (state_reg == ARB) && (|valid_vec);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = (state_reg == ARB) && valid_vec[gi] && (grant_sel == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= INIT;
            count_reg     <= 5'd1;
            rf_we_reg     <= 1'b0;
            rf_waddr_reg  <= 5'd0;
            rf_wdata_reg  <= 32'd0;
            init_done_reg <= 1'b0;
            grant_id_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            rf_we_reg     <= rf_we_next;
            rf_waddr_reg  <= rf_waddr_next;
            rf_wdata_reg  <= rf_wdata_next;
            init_done_reg <= init_done_next;
            grant_id_reg  <= grant_id_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        rf_we_next     = 1'b0;
        rf_waddr_next  = rf_waddr_reg;
        rf_wdata_next  = rf_wdata_reg;
        init_done_next = init_done_reg;
        grant_id_next  = grant_id_reg;
        case (state_reg)
            INIT: begin
                rf_we_next    = 1'b1;
                rf_waddr_next = count_reg;
                rf_wdata_next = 32'd0;
                count_next    = count_reg + 5'd1;
                if (count_reg == 5'd31) begin
                    state_next     = ARB;
                    init_done_next = 1'b1;
                end
            end
            ARB: begin
                if (transfer) begin
                    // x0 is hardwired zero: accept the request but suppress the write strobe.
                    rf_we_next    = (addr_vec[grant_sel] != 5'd0);
                    rf_waddr_next = addr_vec[grant_sel];
                    rf_wdata_next = data_vec[grant_sel];
                    grant_id_next = grant_sel;
                end
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign bus.req0_ready = ready_vec[0];
    assign bus.req1_ready = ready_vec[1];
    assign bus.rf_we      = rf_we_reg;
    assign bus.rf_waddr   = rf_waddr_reg;
    assign bus.rf_wdata   = rf_wdata_reg;
    assign bus.init_done  = init_done_reg;
    assign bus.grant_id   = grant_id_reg;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized self-checking bench for regfile_wb_arbiter.
// It checks against a requester and regfile model, and follows WB_ARB_ROUND_ROBIN_EN like the design.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Requester model: a request stays pending until the arbiter takes it.
    bit          pend  [2];
    logic [4:0]  paddr [2];
    logic [31:0] pdata [2];
    bit          pref1;

    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_gid;

    logic [31:0] model_rf [32];
    logic [31:0] seen_rf  [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pick(input bit v0, input bit v1, input bit p1);
        if (v0 && v1) return RR ? p1 : 1'b0;
        return v1 && !v0;
    endfunction

    task automatic drive_inputs();
        bus.req0_valid = pend[0];
        bus.req0_addr  = paddr[0];
        bus.req0_data  = pdata[0];
        bus.req1_valid = pend[1];
        bus.req1_addr  = paddr[1];
        bus.req1_data  = pdata[1];
    endtask

    task automatic check_outputs(input string where);
        chk({where, "_rf_we"},     {31'd0, bus.rf_we},     {31'd0, exp_we});
        chk({where, "_rf_waddr"},  {27'd0, bus.rf_waddr},  {27'd0, exp_addr});
        chk({where, "_rf_wdata"},  bus.rf_wdata,           exp_data);
        chk({where, "_grant_id"},  {31'd0, bus.grant_id},  {31'd0, exp_gid});
    endtask

    // One arbitration cycle, entered and left at a negedge.
    task automatic arb_cycle();
        bit g;
        bit xfer;
        drive_inputs();
        #1;
        g    = pick(pend[0], pend[1], pref1);
        xfer = pend[0] || pend[1];
        chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, pend[0] && !g});
        chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, pend[1] && g});
        @(posedge clk);
        #1;
        if (xfer) begin
            exp_we   = (paddr[g] != 5'd0);
            exp_addr = paddr[g];
            exp_data = pdata[g];
            exp_gid  = g;
            if (RR) pref1 = !g;
            if (exp_we) model_rf[paddr[g]] = pdata[g];
            pend[g] = 1'b0;
            $display("xfer req%0d addr %0d data %08h we %0d", g, exp_addr, exp_data, exp_we);
        end else begin
            exp_we = 1'b0;
        end
        check_outputs("arb");
        chk("arb_init_done", {31'd0, bus.init_done}, 32'd1);
        if (bus.rf_we) seen_rf[bus.rf_waddr] = bus.rf_wdata;
        @(negedge clk);
    endtask

    // Zero sweep after reset release, entered at the release negedge; optional rst pulse at abort_at.
    task automatic sweep(input int abort_at);
        pref1 = 1'b0;
        drive_inputs();
        chk("sweep_init_done_start", {31'd0, bus.init_done}, 32'd0);
        for (int i = 1; i <= 31; i++) begin
            #1;
            chk("sweep_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
            chk("sweep_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk("sweep_rf_we",     {31'd0, bus.rf_we},     32'd1);
            chk("sweep_rf_waddr",  {27'd0, bus.rf_waddr},  i);
            chk("sweep_rf_wdata",  bus.rf_wdata,           32'd0);
            chk("sweep_init_done", {31'd0, bus.init_done}, (i == 31) ? 32'd1 : 32'd0);
            if (bus.rf_we) seen_rf[bus.rf_waddr] = bus.rf_wdata;
            model_rf[i] = 32'd0;
            $display("sweep write addr %0d", i);
            if (i == abort_at) begin
                #2;
                rst = 1'b1;
                #1;
                exp_we = 1'b0; exp_addr = 5'd0; exp_data = 32'd0; exp_gid = 1'b0;
                check_outputs("abort");
                chk("abort_init_done", {31'd0, bus.init_done}, 32'd0);
                chk("abort_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        exp_we = 1'b1; exp_addr = 5'd31; exp_data = 32'd0; exp_gid = 1'b0;
    endtask

    task automatic random_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom % 3 != 0)) begin
                    pend[r]  = 1'b1;
                    paddr[r] = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    pdata[r] = $urandom;
                end
            end
            arb_cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = 32'hFFFF_FFFF;
            seen_rf[i]  = 32'hFFFF_FFFF;
        end
        rst = 1'b1;
        pend[0] = 1'b1; paddr[0] = 5'd7; pdata[0] = 32'h1234_5678;
        pend[1] = 1'b1; paddr[1] = 5'd9; pdata[1] = 32'h9ABC_DEF0;
        pref1 = 1'b0;
        drive_inputs();
        #12;
        exp_we = 1'b0; exp_addr = 5'd0; exp_data = 32'd0; exp_gid = 1'b0;
        check_outputs("reset");
        chk("reset_init_done",  {31'd0, bus.init_done},  32'd0);
        chk("reset_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        chk("reset_req1_ready", {31'd0, bus.req1_ready}, 32'd0);

        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drive_inputs();
        @(negedge clk);
        rst = 1'b0;
        sweep(0);

        // Four cycles of same-address contention.
        for (int k = 0; k < 4; k++) begin
            pend[0] = 1'b1; paddr[0] = 5'd3; pdata[0] = 32'h11;
            pend[1] = 1'b1; paddr[1] = 5'd3; pdata[1] = 32'h22;
            arb_cycle();
            chk("contention_grant", {31'd0, bus.grant_id}, RR ? (k % 2) : 0);
        end
        pend[0] = 1'b0;
        for (int k = 0; k < 2 && pend[1]; k++) arb_cycle();

        pend[0] = 1'b1; paddr[0] = 5'd5; pdata[0] = 32'hDEAD_BEEF;
        arb_cycle();
        chk("single_wdata", bus.rf_wdata, 32'hDEAD_BEEF);

        pend[1] = 1'b1; paddr[1] = 5'd0; pdata[1] = 32'h55;
        arb_cycle();
        chk("addr0_we", {31'd0, bus.rf_we}, 32'd0);

        random_cycles(300);

        // Reset while requests are pending, then abort a sweep at address 10.
        pend[0] = 1'b1; paddr[0] = 5'd12; pdata[0] = $urandom;
        pend[1] = 1'b1; paddr[1] = 5'd13; pdata[1] = $urandom;
        drive_inputs();
        rst = 1'b1;
        #1;
        chk("rst2_rf_we", {31'd0, bus.rf_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sweep(10);
        @(negedge clk);
        rst = 1'b0;
        sweep(0);
        random_cycles(60);

        for (int i = 0; i < 32; i++) begin
            chk($sformatf("rf_x%0d", i), seen_rf[i], model_rf[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on posedge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: req0_valid in 1, req0_ready out 1, req0_addr in 5, req0_data in 32 (requester 0, ALU writeback).
REQ-004 SHALL have: req1_valid in 1, req1_ready out 1, req1_addr in 5, req1_data in 32 (requester 1, memory/multi-cycle writeback).
REQ-005 SHALL have: rf_we out 1, rf_waddr out 5, rf_wdata out 32 (registered, drive regfile RegWre/waddr/wdata).
REQ-006 SHALL have: init_done out 1 (sweep complete), grant_id out 1 (requester of last accepted transfer).

Function
REQ-007 SHALL implement FSM states INIT and ARB; reset enters INIT.
REQ-008 INIT SHALL hold 5-bit sweep counter starting at 1; each posedge: rf_we=1, rf_waddr=counter, rf_wdata=0, counter+1.
REQ-009 After the edge loading rf_waddr=31, FSM SHALL enter ARB and init_done SHALL be 1 from that edge; 31 sweep writes total, address 0 never written.
REQ-010 In INIT both readies SHALL be 0; valids ignored.
REQ-011 In ARB, readies SHALL be combinational: exactly one ready high (the granted requester) when any valid is high; both 0 when no valid.
REQ-012 Transfer = valid & ready; on transfer edge outputs SHALL load rf_we=1, addr, data, grant_id=index; 1-cycle latency, one write per cycle max.
REQ-013 Cycle with no transfer SHALL load rf_we=0; rf_waddr/rf_wdata hold previous values.
REQ-014 Transfer with addr 0 SHALL be accepted (ready=1) but load rf_we=0.
REQ-015 Both valid, same address: only the granted one transfers; loser stays pending and writes next cycle; final regfile value = later-granted data.
REQ-016 Requesters SHALL hold valid/addr/data stable until ready; block does not check.
REQ-017 Back-to-back transfers from one requester SHALL be allowed every cycle when it is the only valid.

Reset
REQ-018 rst high SHALL immediately force rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, grant_id=0, readies=0, state=INIT, counter=1, priority pointer=0.
REQ-019 rst asserted mid-sweep or mid-transfer SHALL abort; pending request is not written; sweep restarts at address 1 after release.
REQ-020 First sweep write SHALL load on the first posedge after rst deasserts.

Configuration
REQ-021 Macro WB_ARB_ROUND_ROBIN_EN defined: 1-bit priority pointer; on contention grant pointer side; after any transfer pointer SHALL point to the other requester.
REQ-022 Macro undefined: fixed priority, req0 always wins contention, pointer logic absent; req1 may starve.

Verification
REQ-023 Reset release, no valids -> rf_we=1 with addr 1..31, data 0 on cycles 1..31; init_done=1 after 31st; readies 0 throughout.
REQ-024 ARB, req0_valid addr 5 data 0xDEADBEEF, req1 idle -> req0_ready=1 same cycle; next edge rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, grant_id=0.
REQ-025 Both valid 4 cycles (req0 addr 3/0x11, req1 addr 3/0x22), RR build -> grants alternate 0,1; with macro off req0 granted all 4, req1_ready=0.
REQ-026 req1_valid addr 0 data 0x55 -> req1_ready=1, following cycle rf_we=0.
REQ-027 rst pulsed at sweep address 10 -> outputs zero immediately; after release sweep restarts at 1, init_done low until 31 writes complete.
